decode_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/decode_comb.sv | 128 ++++++++++++
 rtl/decode_stage.sv | 140 ++++++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: opcode class enum, major opcode constants,
// raw instruction layout and the width-independent part of the decoded bundle.
package riscv_pkg;

  typedef enum logic [3:0] {
    OPC_LOAD     = 4'd0,
    OPC_MISC_MEM = 4'd1,
    OPC_OP_IMM   = 4'd2,
    OPC_AUIPC    = 4'd3,
    OPC_OP       = 4'd4,
    OPC_LUI      = 4'd5,
    OPC_STORE    = 4'd6,
    OPC_BRANCH   = 4'd7,
    OPC_JALR     = 4'd8,
    OPC_JAL      = 4'd9,
    OPC_SYSTEM   = 4'd10,
    OPC_ILLEGAL  = 4'd11
  } op_class_t;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  // pc and imm depend on XLEN, which a package cannot see, so they travel
  // alongside this struct rather than inside it.
  typedef struct packed {
    op_class_t  op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I decoder: field split, immediate
// generation, opcode classification and illegal-encoding detection.
module decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_M   = 1'b0,
  parameter bit          EN_CSR = 1'b1
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  instr_t             ins;
  logic [31:0]        imm_i;
  logic [31:0]        imm_s;
  logic [31:0]        imm_b;
  logic [31:0]        imm_u;
  logic [31:0]        imm_j;
  logic signed [31:0] imm32;
  op_class_t          cls;
  logic               legal;

  assign ins   = instr;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Immediate format follows the major opcode even when the encoding is illegal.
  assign imm = XLEN'(imm32);

  // Classify the opcode, pick the immediate format and check encoding legality.
  always_comb begin
    cls   = OPC_ILLEGAL;
    imm32 = '0;
    legal = 1'b0;
    case (ins.opcode)
      OPCODE_LOAD: begin
        cls   = OPC_LOAD;
        imm32 = imm_i;
        legal = (ins.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                (RV64 && (ins.funct3 inside {3'b011, 3'b110}));
      end
      OPCODE_MISC_MEM: begin
        cls   = OPC_MISC_MEM;
        imm32 = imm_i;
        legal = 1'b1;
      end
      OPCODE_OP_IMM: begin
        cls   = OPC_OP_IMM;
        imm32 = imm_i;
        case (ins.funct3)
          3'b001:  legal = RV64 ? (instr[31:26] == 6'b000000)
                                : (instr[31:25] == 7'b0000000);
          3'b101:  legal = RV64 ? (instr[31:26] inside {6'b000000, 6'b010000})
                                : (instr[31:25] inside {7'b0000000, 7'b0100000});
          default: legal = 1'b1;
        endcase
      end
      OPCODE_AUIPC: begin
        cls   = OPC_AUIPC;
        imm32 = imm_u;
        legal = 1'b1;
      end
      OPCODE_OP: begin
        cls   = OPC_OP;
        legal = (ins.funct7 == 7'b0000000) ||
                ((ins.funct7 == 7'b0100000) && (ins.funct3 inside {3'b000, 3'b101})) ||
                (EN_M && (ins.funct7 == 7'b0000001));
      end
      OPCODE_LUI: begin
        cls   = OPC_LUI;
        imm32 = imm_u;
        legal = 1'b1;
      end
      OPCODE_STORE: begin
        cls   = OPC_STORE;
        imm32 = imm_s;
        legal = (ins.funct3 <= 3'b010) || (RV64 && (ins.funct3 == 3'b011));
      end
      OPCODE_BRANCH: begin
        cls   = OPC_BRANCH;
        imm32 = imm_b;
        legal = !(ins.funct3 inside {3'b010, 3'b011});
      end
      OPCODE_JALR: begin
        cls   = OPC_JALR;
        imm32 = imm_i;
        legal = (ins.funct3 == 3'b000);
      end
      OPCODE_JAL: begin
        cls   = OPC_JAL;
        imm32 = imm_j;
        legal = 1'b1;
      end
      OPCODE_SYSTEM: begin
        cls   = OPC_SYSTEM;
        imm32 = imm_i;
        legal = (ins.funct3 == 3'b000) || (EN_CSR && (ins.funct3 != 3'b100));
      end
      default: begin
        cls   = OPC_ILLEGAL;
        imm32 = '0;
        legal = 1'b0;
      end
    endcase
    if ((instr[1:0] != 2'b11) || (instr == '0) || (instr == '1)) begin
      legal = 1'b0;
    end
  end

  // Assemble the decoded bundle; illegal encodings keep their fields.
  always_comb begin
    dec.op      = legal ? cls : OPC_ILLEGAL;
    dec.rd      = ins.rd;
    dec.rs1     = ins.rs1;
    dec.rs2     = ins.rs2;
    dec.funct3  = ins.funct3;
    dec.funct7  = ins.funct7;
    dec.illegal = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready on both sides with a one-entry skid
// buffer so a full-rate stream survives downstream backpressure.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_M   = 1'b0,
  parameter bit          EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t            state_q, state_d;
  decoded_t        dec_c;
  logic [XLEN-1:0] imm_c;
  decoded_t        main_q, main_d, skid_q, skid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic            accept;
  logic            drain;

  decode_comb #(
    .XLEN   (XLEN),
    .EN_M   (EN_M),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr (in_instr),
    .dec   (dec_c),
    .imm   (imm_c)
  );

  // Ready depends only on occupancy, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Occupancy transitions and main/skid data movement.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_pc_d  = main_pc_q;
    main_imm_d = main_imm_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    skid_imm_d = skid_imm_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d     = dec_c;
            main_pc_d  = in_pc;
            main_imm_d = imm_c;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d     = dec_c;
            main_pc_d  = in_pc;
            main_imm_d = imm_c;
          end else if (accept) begin
            skid_d     = dec_c;
            skid_pc_d  = in_pc;
            skid_imm_d = imm_c;
            state_d    = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d     = skid_q;
            main_pc_d  = skid_pc_q;
            main_imm_d = skid_imm_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      main_pc_q  <= '0;
      main_imm_q <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      skid_imm_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_pc_q  <= main_pc_d;
      main_imm_q <= main_imm_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      skid_imm_q <= skid_imm_d;
    end
  end

  assign out_pc      = main_pc_q;
  assign out_op      = main_q.op;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm     = main_imm_q;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 (EN_M=0, EN_CSR=1) and an RV64 (EN_M=1,
// EN_CSR=0) instance share one input stream; a queue-based reference model
// predicts occupancy and the decoded bundle of the oldest held instruction.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [3:0]  a_op;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [3:0]  b_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_CSR(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_op(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_illegal(a_ill));

  decode_stage #(.XLEN(64), .EN_M(1'b1), .EN_CSR(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_op(b_op), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_illegal(b_ill));

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int emitted = 0;
  logic [6:0] opcs[12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h33, 7'h37,
                           7'h23, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h5B};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode computed from the ISA field rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input int xlen,
                                      input bit en_m, input bit en_csr);
    exp_t e;
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    int hi6 = int'(ins[31:26]);
    longint i_imm, s_imm, b_imm, u_imm, j_imm, imm;
    logic [3:0] cls;
    bit legal;
    i_imm = longint'(ins[31:20]);
    if (ins[31]) i_imm -= 4096;
    s_imm = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
    if (ins[31]) s_imm -= 4096;
    b_imm = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
    if (ins[31]) b_imm -= 4096;
    u_imm = longint'(ins[31:12]) * 4096;
    if (ins[31]) u_imm -= 64'h1_0000_0000;
    j_imm = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
    if (ins[31]) j_imm -= 1048576;
    cls = OPC_ILLEGAL; imm = 0; legal = 0;
    case (ins[6:0])
      7'h03: begin cls = OPC_LOAD; imm = i_imm;
        legal = (f3 inside {0, 1, 2, 4, 5}) || (xlen == 64 && (f3 inside {3, 6})); end
      7'h0F: begin cls = OPC_MISC_MEM; imm = i_imm; legal = 1; end
      7'h13: begin cls = OPC_OP_IMM; imm = i_imm;
        if (f3 == 1) legal = (xlen == 64) ? (hi6 == 0) : (f7 == 0);
        else if (f3 == 5) legal = (xlen == 64) ? (hi6 == 0 || hi6 == 16) : (f7 == 0 || f7 == 32);
        else legal = 1; end
      7'h17: begin cls = OPC_AUIPC; imm = u_imm; legal = 1; end
      7'h33: begin cls = OPC_OP; imm = 0;
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (en_m && f7 == 1); end
      7'h37: begin cls = OPC_LUI; imm = u_imm; legal = 1; end
      7'h23: begin cls = OPC_STORE; imm = s_imm; legal = (f3 <= 2) || (xlen == 64 && f3 == 3); end
      7'h63: begin cls = OPC_BRANCH; imm = b_imm; legal = !(f3 == 2 || f3 == 3); end
      7'h67: begin cls = OPC_JALR; imm = i_imm; legal = (f3 == 0); end
      7'h6F: begin cls = OPC_JAL; imm = j_imm; legal = 1; end
      7'h73: begin cls = OPC_SYSTEM; imm = i_imm; legal = (f3 == 0) || (en_csr && f3 != 4); end
      default: begin cls = OPC_ILLEGAL; imm = 0; legal = 0; end
    endcase
    if (ins[1:0] != 2'b11 || ins == 32'h0 || ins == 32'hFFFF_FFFF) legal = 0;
    e.op  = legal ? cls : OPC_ILLEGAL;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    e.imm = imm;
    e.ill = !legal;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 19);
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'hFFFF_FFFF;
    if (sel != 2) r[6:0] = opcs[$urandom_range(0, 11)];
    case ($urandom_range(0, 4))
      0: r[31:25] = 7'b0000000;
      1: r[31:25] = 7'b0100000;
      2: r[31:25] = 7'b0000001;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: drive inputs, check against the model at the falling edge,
  // update the model at the rising edge, return 1 ns after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic r, output bit acc);
    exp_t ea, eb;
    bit drn;
    item_t it;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
    @(negedge clk);
    chk("in_ready32", a_in_ready, q.size() < 2);
    chk("in_ready64", b_in_ready, q.size() < 2);
    chk("out_valid32", a_out_valid, q.size() > 0);
    chk("out_valid64", b_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      ea = ref_decode(q[0].instr, 32, 1'b0, 1'b1);
      eb = ref_decode(q[0].instr, 64, 1'b1, 1'b0);
      chk("bundle32", {a_pc, a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, a_ill},
          {q[0].pc[31:0], ea.op, ea.rd, ea.rs1, ea.rs2, ea.f3, ea.f7, ea.imm[31:0], ea.ill});
      chk("bundle64", {b_pc, b_op, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm, b_ill},
          {q[0].pc, eb.op, eb.rd, eb.rs1, eb.rs2, eb.f3, eb.f7, eb.imm, eb.ill});
    end
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge clk);
    if (r || fl) begin
      q.delete();
    end else begin
      if (drn) begin
        void'(q.pop_front());
        emitted++;
      end
      if (acc) begin
        it.instr = ins;
        it.pc = pc;
        q.push_back(it);
      end
    end
    #1;
  endtask

  initial begin
    bit acc;
    int sent;
    int base;
    logic [31:0] bp[4];
    logic [31:0] cur;
    bp[0] = 32'h0010_0113; bp[1] = 32'h4020_5193; bp[2] = 32'h0030_2223; bp[3] = 32'h0040_02EF;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid32", a_out_valid, 1'b0);
    chk("rst_out_valid64", b_out_valid, 1'b0);
    chk("rst_in_ready32", a_in_ready, 1'b1);
    chk("rst_in_ready64", b_in_ready, 1'b1);
    chk("rst_data32", {a_pc, a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, a_ill}, '0);
    chk("rst_data64", {b_pc, b_op, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm, b_ill}, '0);

    // Directed decodes, each draining the previous one in the same cycle.
    step(1, 32'hFFF0_0093, 64'h1000, 1, 0, 0, acc);
    chk("addi_op", a_op, OPC_OP_IMM);
    chk("addi_rd", a_rd, 5'd1);
    chk("addi_imm", a_imm, 32'hFFFF_FFFF);
    chk("addi_ill", a_ill, 1'b0);
    step(1, 32'h1234_52B7, 64'h1004, 1, 0, 0, acc);
    chk("lui_imm32", a_imm, 32'h1234_5000);
    chk("lui_rd", a_rd, 5'd5);
    chk("lui_imm64", b_imm, 64'h0000_0000_1234_5000);
    step(1, 32'hFE00_0EE3, 64'h1008, 1, 0, 0, acc);
    chk("beq_op", a_op, OPC_BRANCH);
    chk("beq_imm", a_imm, 32'hFFFF_FFFC);
    step(1, 32'h0220_81B3, 64'h100C, 1, 0, 0, acc);
    chk("mul_ill_nom", a_ill, 1'b1);
    chk("mul_op_nom", a_op, OPC_ILLEGAL);
    chk("mul_op_m", b_op, OPC_OP);
    chk("mul_f7_m", b_f7, 7'b0000001);
    chk("mul_ill_m", b_ill, 1'b0);
    step(0, '0, '0, 1, 0, 0, acc);

    // Backpressure: offer four instructions while downstream stalls.
    base = emitted;
    sent = 0;
    for (int c = 0; c < 3; c++) begin
      step(1, bp[sent], 64'h2000 + 64'(sent * 4), 0, 0, 0, acc);
      if (acc) sent++;
      if (c == 1) chk("bp_in_ready_full", a_in_ready, 1'b0);
    end
    chk("bp_accepted", sent, 2);
    for (int c = 0; c < 20 && (emitted - base) < 4; c++) begin
      cur = (sent < 4) ? bp[sent[1:0]] : 32'h0;
      step(sent < 4, cur, 64'h2000 + 64'(sent * 4), 1, 0, 0, acc);
      if (acc && sent < 4) sent++;
    end
    chk("bp_all_emitted", emitted - base, 4);

    // Flush while FULL with a new instruction offered.
    step(1, 32'h0050_0313, 64'h3000, 0, 0, 0, acc);
    step(1, 32'h0060_0393, 64'h3004, 0, 0, 0, acc);
    step(1, 32'h0070_0413, 64'h3008, 0, 1, 0, acc);
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    repeat (3) step(0, '0, '0, 1, 0, 0, acc);

    // Reset mid-stream behaves like flush.
    step(1, 32'h0080_0493, 64'h4000, 0, 0, 0, acc);
    step(1, 32'h0090_0513, 64'h4004, 0, 0, 0, acc);
    step(1, 32'h00A0_0593, 64'h4008, 0, 0, 1, acc);
    chk("rst_mid_out_valid", b_out_valid, 1'b0);
    chk("rst_mid_in_ready", b_in_ready, 1'b1);
    repeat (3) step(0, '0, '0, 1, 0, 0, acc);

    // Randomized traffic with random backpressure and occasional flush.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, 1'b0, acc);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, '0, '0, 1, 0, 0, acc);
    chk("final_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
